// File: rtl/dmem_responder.sv
// dmem_responder: handshaked, multi-cycle data-memory responder for the MEM stage.
// Byte-addressed little-endian RAM, one request in flight, WAIT_CYCLES wait states,
// then a load response (sign/zero-extended) or a store acknowledge.
// Optional build macro: DMEM_MISALIGN_CHK_EN. When it is defined, misaligned halfword
// and word accesses are reported as errors. When it is not defined, they execute
// byte-wise and wrap around at the top of the RAM.
module dmem_responder #(
  parameter int unsigned DM_ADDRESS  = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned DEPTH = 1 << DM_ADDRESS;
  localparam int unsigned CNT_W = 5;
  // The counter is loaded one above the wait-state count, so the access executes
  // exactly WAIT_CYCLES+1 edges after accept, also when WAIT_CYCLES is 0.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  lat_we;
  logic [DM_ADDRESS-1:0] lat_addr;
  logic [DATA_W-1:0]     lat_wdata;
  logic [2:0]            lat_funct3;

  logic [7:0]            mem [DEPTH];

  logic [DM_ADDRESS-1:0] addr1_c, addr2_c, addr3_c;
  logic [7:0]            b0_c, b1_c, b2_c, b3_c;
  logic                  legal_c;
  logic                  misalign_c;
  logic                  err_c;
  logic                  exec_c;
  logic [DATA_W-1:0]     load_c;

  // Byte lanes of the latched access; the address sum wraps modulo the RAM size
  assign addr1_c = lat_addr + DM_ADDRESS'(1);
  assign addr2_c = lat_addr + DM_ADDRESS'(2);
  assign addr3_c = lat_addr + DM_ADDRESS'(3);
  assign b0_c    = mem[lat_addr];
  assign b1_c    = mem[addr1_c];
  assign b2_c    = mem[addr2_c];
  assign b3_c    = mem[addr3_c];

  // Legal funct3 encodings differ for loads and stores
  always_comb begin
    legal_c = 1'b0;
    if (lat_we) begin
      case (lat_funct3)
        3'b000, 3'b001, 3'b010: legal_c = 1'b1;
        default:                legal_c = 1'b0;
      endcase
    end else begin
      case (lat_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_c = 1'b1;
        default:                                legal_c = 1'b0;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_CHK_EN
  // Halfword needs addr[0]==0 and word needs addr[1:0]==0
  assign misalign_c = ((lat_funct3[1:0] == 2'b01) && lat_addr[0]) ||
                      ((lat_funct3[1:0] == 2'b10) && (lat_addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  assign err_c  = !legal_c || misalign_c;
  assign exec_c = (state == ST_WAIT) && (cnt == CNT_W'(1));

  // Load extension by access size and signedness
  always_comb begin
    load_c = '0;
    case (lat_funct3)
      3'b000:  load_c = DATA_W'({{24{b0_c[7]}}, b0_c});
      3'b001:  load_c = DATA_W'({{16{b1_c[7]}}, b1_c, b0_c});
      3'b010:  load_c = DATA_W'({b3_c, b2_c, b1_c, b0_c});
      3'b100:  load_c = DATA_W'({24'h0, b0_c});
      3'b101:  load_c = DATA_W'({16'h0, b1_c, b0_c});
      default: load_c = '0;
    endcase
  end

  // RAM write on the execute edge; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (exec_c && lat_we && !err_c) begin
      mem[lat_addr] <= lat_wdata[7:0];
      if (lat_funct3[1:0] != 2'b00) begin
        mem[addr1_c] <= lat_wdata[15:8];
      end
      if (lat_funct3[1:0] == 2'b10) begin
        mem[addr2_c] <= lat_wdata[23:16];
        mem[addr3_c] <= lat_wdata[31:24];
      end
    end
  end

  // Request/response FSM with registered handshake and response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            lat_we     <= req_we;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            lat_funct3 <= req_funct3;
            cnt        <= CNT_LOAD;
            req_ready  <= 1'b0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            cnt       <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= err_c;
            rsp_rdata <= (lat_we || err_c) ? '0 : load_c;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed load/store vectors with hand-computed expectations.
module tb_dmem_responder;

  localparam int unsigned AW = 9;
  localparam int unsigned WC = 2;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [2:0]    req_funct3;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  int checks;
  int errors;

  dmem_responder #(.DM_ADDRESS(AW), .DATA_W(32), .WAIT_CYCLES(WC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // One full request/response; checks latency and that rsp_valid drops after handshake
  task automatic xact(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                      input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check("latency", 32'(n), 32'(WC + 1));
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'h0);
  endtask

  task automatic acc(input string tag, input logic we, input logic [AW-1:0] addr,
                     input logic [31:0] wd, input logic [2:0] f3,
                     input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    xact(we, addr, wd, f3, rd, er);
    check(tag, rd, exp_rd);
    check({tag, "_err"}, 32'(er), 32'(exp_er));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    checks = 0; errors = 0;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    rst = 1'b1;

    // Basic word store/load and extension variants
    acc("sw_010", 1'b1, 9'h010, 32'h8765_43A1, 3'b010, 32'h0, 1'b0);
    acc("lw_010", 1'b0, 9'h010, 32'h0, 3'b010, 32'h8765_43A1, 1'b0);
    acc("lb_010", 1'b0, 9'h010, 32'h0, 3'b000, 32'hFFFF_FFA1, 1'b0);
    acc("lbu_010", 1'b0, 9'h010, 32'h0, 3'b100, 32'h0000_00A1, 1'b0);
    acc("lh_012", 1'b0, 9'h012, 32'h0, 3'b001, 32'hFFFF_8765, 1'b0);
    acc("lhu_012", 1'b0, 9'h012, 32'h0, 3'b101, 32'h0000_8765, 1'b0);

    // Byte store leaves neighbours intact
    acc("sb_011", 1'b1, 9'h011, 32'h0000_00CC, 3'b000, 32'h0, 1'b0);
    acc("lw_after_sb", 1'b0, 9'h010, 32'h0, 3'b010, 32'h8765_CCA1, 1'b0);

    // Backpressure: response held while a second request is pending on the inputs
    @(negedge clk);
    req_we = 1'b0; req_addr = 9'h010; req_funct3 = 3'b010; req_valid = 1'b1;
    @(posedge clk);
    #1 req_we = 1'b1; req_wdata = 32'h0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check("stall_latency", 32'(n), 32'(WC + 1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", 32'(rsp_valid), 32'h1);
      check("stall_rdata", rsp_rdata, 32'h8765_CCA1);
      check("stall_req_ready", 32'(req_ready), 32'h0);
    end
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("release_req_ready", 32'(req_ready), 32'h1);
    check("release_rsp_valid", 32'(rsp_valid), 32'h0);
    acc("no_second_accept", 1'b0, 9'h010, 32'h0, 3'b010, 32'h8765_CCA1, 1'b0);

    // Illegal funct3 on store and load
    acc("st_f3_011", 1'b1, 9'h010, 32'hFFFF_FFFF, 3'b011, 32'h0, 1'b1);
    acc("ld_f3_011", 1'b0, 9'h010, 32'h0, 3'b011, 32'h0, 1'b1);
    acc("ld_f3_110", 1'b0, 9'h010, 32'h0, 3'b110, 32'h0, 1'b1);
    acc("lw_after_illegal", 1'b0, 9'h010, 32'h0, 3'b010, 32'h8765_CCA1, 1'b0);

    // Misaligned accesses
    acc("sw_014", 1'b1, 9'h014, 32'h1122_3344, 3'b010, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_CHK_EN
    acc("lw_011_mis", 1'b0, 9'h011, 32'h0, 3'b010, 32'h0, 1'b1);
    acc("lh_013_mis", 1'b0, 9'h013, 32'h0, 3'b001, 32'h0, 1'b1);
    acc("sw_1fe_mis", 1'b1, 9'h1FE, 32'hAABB_CCDD, 3'b010, 32'h0, 1'b1);
    acc("lw_010_kept", 1'b0, 9'h010, 32'h0, 3'b010, 32'h8765_CCA1, 1'b0);
`else
    acc("lw_011", 1'b0, 9'h011, 32'h0, 3'b010, 32'h4487_65CC, 1'b0);
    acc("sw_000", 1'b1, 9'h000, 32'h0000_0000, 3'b010, 32'h0, 1'b0);
    acc("sw_1fe_wrap", 1'b1, 9'h1FE, 32'hAABB_CCDD, 3'b010, 32'h0, 1'b0);
    acc("lw_1fe_wrap", 1'b0, 9'h1FE, 32'h0, 3'b010, 32'hAABB_CCDD, 1'b0);
    acc("lw_000_wrap", 1'b0, 9'h000, 32'h0, 3'b010, 32'h0000_AABB, 1'b0);
    acc("lhu_1ff_wrap", 1'b0, 9'h1FF, 32'h0, 3'b101, 32'h0000_BBCC, 1'b0);
`endif

    // Reset during WAIT drops the unexecuted store
    acc("lw_pre_rst", 1'b0, 9'h010, 32'h0, 3'b010, 32'h8765_CCA1, 1'b0);
    @(negedge clk);
    req_we = 1'b1; req_addr = 9'h010; req_wdata = 32'hDEAD_BEEF; req_funct3 = 3'b010;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("wait_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'h1);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_rsp_rdata", rsp_rdata, 32'h0);
    check("mid_rst_rsp_err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    acc("lw_after_rst", 1'b0, 9'h010, 32'h0, 3'b010, 32'h8765_CCA1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
